// File: rtl/sum_burst_pkg.sv
// sum_burst_pkg: shared types, default widths and the accumulator add helper
// for sum_burst_accum.
//
// Build option:
//   SUM_BURST_ACCUM_SAT_EN  defined   -> accumulator saturates at 2^ACC_W-1
//                           undefined -> accumulator wraps modulo 2^ACC_W
// In both cases the returned overflow flag reports a carry out of ACC_W.
package sum_burst_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } burst_state_e;

    localparam int DEF_DATA_W    = 9;
    localparam int DEF_BURST_LEN = 5;
    localparam int DEF_ACC_W     = 12;
    localparam int DEF_CNT_W     = 8;

    // Widest accumulator the helper supports. The result carries one extra
    // bit on top for the overflow flag.
    localparam int MAX_ACC_W = 32;

    // Returns {ovf, sum}; sum is valid in bits [acc_w-1:0], upper bits are 0.
    function automatic logic [MAX_ACC_W:0] add_sat_or_wrap(
        input int unsigned          acc_w,
        input logic [MAX_ACC_W-1:0] acc,
        input logic [MAX_ACC_W-1:0] data
    );
        logic [MAX_ACC_W:0]   full;
        logic [MAX_ACC_W:0]   lim;
        logic                 ovf;
        logic [MAX_ACC_W-1:0] res;
        full = {1'b0, acc} + {1'b0, data};
        lim  = ({{MAX_ACC_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
        ovf  = (full > lim);
`ifdef SUM_BURST_ACCUM_SAT_EN
        res  = ovf ? lim[MAX_ACC_W-1:0] : full[MAX_ACC_W-1:0];
`else
        res  = full[MAX_ACC_W-1:0] & lim[MAX_ACC_W-1:0];
`endif
        return {ovf, res};
    endfunction

endpackage

// File: rtl/sum_burst_accum.sv
// sum_burst_accum: accumulates BURST_LEN adder results (carry in the MSB),
// counts carry-set samples and presents the burst summary on a valid/ready
// output. A flush closes a partial burst early.
//
// Ports:
//   clk, clear_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data    upstream sum stream, in_data[DATA_W-1] = carry
//   flush                        close the current partial burst
//   out_valid/out_ready          burst result handshake
//   out_sum, out_carry_cnt,      burst total, carry count, sample count,
//   out_count, out_ovf           accumulator overflow flag
//
// Build option: SUM_BURST_ACCUM_SAT_EN selects saturating accumulation
// (see sum_burst_pkg::add_sat_or_wrap); default is modulo wrap.
import sum_burst_pkg::*;

module sum_burst_accum #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,  // 1..255
    parameter int ACC_W     = DEF_ACC_W,      // DATA_W..MAX_ACC_W-1
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_carry_cnt,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    burst_state_e     state_q, state_nx;
    logic [ACC_W-1:0] acc_q, acc_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [CNT_W-1:0] carry_q, carry_nx;
    logic             ovf_q, ovf_nx;

    logic               accept;
    logic               close;
    logic               release_hold;
    logic [MAX_ACC_W:0] add_r;
    logic               unused_add_hi;

    // Gate with clear_n so upstream never sees ready while in reset.
    assign in_ready     = clear_n && (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign accept       = in_valid && in_ready;
    assign release_hold = out_valid && out_ready;

    assign add_r = add_sat_or_wrap(ACC_W, MAX_ACC_W'(acc_q), MAX_ACC_W'(in_data));
    // Bits above ACC_W are always zero from the helper.
    assign unused_add_hi = ^add_r[MAX_ACC_W-1:ACC_W];

    // Post-update values: these are what a closing burst publishes.
    always_comb begin
        acc_nx   = acc_q;
        cnt_nx   = cnt_q;
        carry_nx = carry_q;
        ovf_nx   = ovf_q;
        if (accept) begin
            acc_nx   = add_r[ACC_W-1:0];
            cnt_nx   = cnt_q + 1'b1;
            carry_nx = carry_q + CNT_W'(in_data[DATA_W-1]);
            ovf_nx   = ovf_q | add_r[MAX_ACC_W];
        end
    end

    always_comb begin
        close = 1'b0;
        if (state_q == ACCUM) begin
            close = (accept && (cnt_nx == CNT_W'(BURST_LEN)))
                 || (flush && ((cnt_q != '0) || accept));
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ACCUM:   if (close)        state_nx = HOLD;
            HOLD:    if (release_hold) state_nx = ACCUM;
            default:                   state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else if (release_hold) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_nx;
            cnt_q   <= cnt_nx;
            carry_q <= carry_nx;
            ovf_q   <= ovf_nx;
        end
    end

    // Result registers only move on a close, so they hold through HOLD.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_sum       <= '0;
            out_carry_cnt <= '0;
            out_count     <= '0;
            out_ovf       <= 1'b0;
        end else if (close) begin
            out_sum       <= acc_nx;
            out_carry_cnt <= carry_nx;
            out_count     <= cnt_nx;
            out_ovf       <= ovf_nx;
        end
    end

endmodule
